// File: rtl/tap_bram_arbiter_if.sv
// Tap BRAM arbiter bus: AXI slave, FIR core and BRAM pin bundle.
// slave = arbiter side, master = requester/BRAM side.
interface tap_bram_arbiter_if #(
  parameter int pDATA_WIDTH   = 32,
  parameter int TAP_NUM_WIDTH = 10
);
  localparam int WEW = pDATA_WIDTH / 8;

  logic                     in_axi_rd_req;
  logic                     in_axi_wr_req;
  logic [TAP_NUM_WIDTH-1:0] in_axi_A;
  logic [WEW-1:0]           in_axi_WE;
  logic [pDATA_WIDTH-1:0]   in_axi_Di;
  logic                     out_arbit_arready;
  logic                     out_arbit_rvalid;
  logic                     out_arbit_awready;
  logic                     out_arbit_wready;
  logic                     in_core_req;
  logic [TAP_NUM_WIDTH-1:0] in_core_A;
  logic                     out_core_gnt;
  logic                     out_core_rvalid;
  logic                     in_ap_busy;
  logic                     out_wr_blocked;
  logic                     out_tap_EN;
  logic [TAP_NUM_WIDTH-1:0] out_tap_A;
  logic [WEW-1:0]           out_tap_WE;
  logic [pDATA_WIDTH-1:0]   out_tap_Di;

  modport slave (
    input  in_axi_rd_req, in_axi_wr_req,
    input  in_axi_A, in_axi_WE, in_axi_Di,
    output out_arbit_arready, out_arbit_rvalid,
    output out_arbit_awready, out_arbit_wready,
    input  in_core_req, in_core_A,
    output out_core_gnt, out_core_rvalid,
    input  in_ap_busy,
    output out_wr_blocked,
    output out_tap_EN, out_tap_A,
    output out_tap_WE, out_tap_Di
  );

  modport master (
    output in_axi_rd_req, in_axi_wr_req,
    output in_axi_A, in_axi_WE, in_axi_Di,
    input  out_arbit_arready, out_arbit_rvalid,
    input  out_arbit_awready, out_arbit_wready,
    output in_core_req, in_core_A,
    input  out_core_gnt, out_core_rvalid,
    output in_ap_busy,
    input  out_wr_blocked,
    input  out_tap_EN, out_tap_A,
    input  out_tap_WE, out_tap_Di
  );
endinterface

// File: rtl/tap_bram_arbiter.sv
// Single-port tap BRAM arbiter: AXI slave vs FIR core, bounded AXI starvation.
// Optional TAP_WR_LOCK_EN: refuse AXI writes while the core is busy.
module tap_bram_arbiter #(
  parameter int pDATA_WIDTH   = 32,
  parameter int TAP_NUM_WIDTH = 10,
  parameter int MAX_WAIT      = 4
) (
  input logic aclk,
  input logic areset,
  tap_bram_arbiter_if.slave bus
);
  localparam int WEW = pDATA_WIDTH / 8;
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  logic [3:0] wait_q, wait_d;
  logic       ar_rv_q, ar_rv_d;
  logic       co_rv_q, co_rv_d;
  logic       wr_ok;
  logic       axi_pend;
  logic       promote;
  logic       axi_win;
  logic       g_wr, g_rd, g_core;

  always_comb begin
    wr_ok = bus.in_axi_wr_req;
`ifdef TAP_WR_LOCK_EN
    wr_ok = bus.in_axi_wr_req & ~bus.in_ap_busy;
`endif
    axi_pend = bus.in_axi_rd_req | wr_ok;
    promote  = bus.in_ap_busy & (wait_q == MAX_W);
    axi_win  = ~areset & axi_pend &
               (~bus.in_ap_busy | ~bus.in_core_req | promote);
    g_wr     = axi_win & wr_ok;
    g_rd     = axi_win & ~wr_ok;
    g_core   = ~areset & bus.in_core_req & ~axi_win;

    wait_d = wait_q;
    if (areset || !axi_pend || axi_win)
      wait_d = '0;
    else if (g_core && bus.in_ap_busy)
      wait_d = wait_q + 4'd1;

    ar_rv_d = g_rd;
    co_rv_d = g_core;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wait_q  <= '0;
      ar_rv_q <= 1'b0;
      co_rv_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      ar_rv_q <= ar_rv_d;
      co_rv_q <= co_rv_d;
    end
  end

`ifdef TAP_WR_LOCK_EN
  logic blk_q, blk_d;

  always_comb begin
    blk_d = blk_q | (bus.in_axi_wr_req & bus.in_ap_busy);
  end

  always_ff @(posedge aclk) begin
    if (areset) blk_q <= 1'b0;
    else        blk_q <= blk_d;
  end

  assign bus.out_wr_blocked = blk_q;
`else
  assign bus.out_wr_blocked = 1'b0;
`endif

  assign bus.out_arbit_arready = g_rd;
  assign bus.out_arbit_awready = g_wr;
  assign bus.out_arbit_wready  = g_wr;
  assign bus.out_core_gnt      = g_core;

  // A pending read pulse is squashed while reset is held.
  assign bus.out_arbit_rvalid = ar_rv_q & ~areset;
  assign bus.out_core_rvalid  = co_rv_q & ~areset;

  assign bus.out_tap_EN = g_wr | g_rd | g_core;
  assign bus.out_tap_A  = (g_wr | g_rd) ? bus.in_axi_A :
                          g_core        ? bus.in_core_A :
                                          '0;
  assign bus.out_tap_WE = g_wr ? bus.in_axi_WE : {WEW{1'b0}};
  assign bus.out_tap_Di = g_wr ? bus.in_axi_Di : '0;
endmodule

// File: tb/tb_tap_bram_arbiter.sv
// Directed bench for tap_bram_arbiter with a behavioural tap BRAM.
// Build with +define+TAP_WR_LOCK_EN to exercise the write lock.
module tb_tap_bram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tap_bram_arbiter_if #(
    .pDATA_WIDTH(32), .TAP_NUM_WIDTH(10)
  ) bus ();

  tap_bram_arbiter #(
    .pDATA_WIDTH(32), .TAP_NUM_WIDTH(10), .MAX_WAIT(4)
  ) dut (
    .aclk(clk), .areset(rst), .bus(bus)
  );

  logic [31:0] mem [0:1023];
  logic [31:0] do_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
      do_q <= '0;
    end else if (bus.out_tap_EN) begin
      for (int b = 0; b < 4; b++)
        if (bus.out_tap_WE[b])
          mem[bus.out_tap_A][b*8 +: 8] <= bus.out_tap_Di[b*8 +: 8];
      do_q <= mem[bus.out_tap_A];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_axi_rd_req = 1'b0;
    bus.in_axi_wr_req = 1'b0;
    bus.in_axi_A      = '0;
    bus.in_axi_WE     = '0;
    bus.in_axi_Di     = '0;
    bus.in_core_req   = 1'b0;
    bus.in_core_A     = '0;
    bus.in_ap_busy    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_axi_rd_req = 1'b1;
    bus.in_axi_wr_req = 1'b1;
    bus.in_core_req   = 1'b1;
    bus.in_axi_A      = 10'd5;
    bus.in_axi_WE     = 4'hF;
    bus.in_axi_Di     = 32'hFFFF_FFFF;
    tick();
    @(negedge clk);
    checks++;
    if ({bus.out_arbit_arready, bus.out_arbit_awready,
         bus.out_arbit_wready, bus.out_core_gnt} !== 4'b0) begin
      errors++;
      $display("FAIL reset_grants: got %b want 0000",
        {bus.out_arbit_arready, bus.out_arbit_awready,
         bus.out_arbit_wready, bus.out_core_gnt});
    end
    checks++;
    if ({bus.out_tap_EN, bus.out_tap_WE} !== 5'b0) begin
      errors++;
      $display("FAIL reset_en_we: got %b want 0",
        {bus.out_tap_EN, bus.out_tap_WE});
    end
    checks++;
    if (bus.out_tap_A !== 10'd0 || bus.out_tap_Di !== 32'd0) begin
      errors++;
      $display("FAIL reset_a_di: got A=%h Di=%h want 0",
        bus.out_tap_A, bus.out_tap_Di);
    end
    checks++;
    if ({bus.out_arbit_rvalid, bus.out_core_rvalid,
         bus.out_wr_blocked} !== 3'b0) begin
      errors++;
      $display("FAIL reset_regs: got %b want 000",
        {bus.out_arbit_rvalid, bus.out_core_rvalid,
         bus.out_wr_blocked});
    end
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_wr_rd();
    bus.in_axi_wr_req = 1'b1;
    bus.in_axi_A      = 10'd5;
    bus.in_axi_WE     = 4'hF;
    bus.in_axi_Di     = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({bus.out_arbit_awready, bus.out_arbit_wready,
         bus.out_tap_EN} !== 3'b111 ||
        bus.out_tap_WE !== 4'hF || bus.out_tap_A !== 10'd5 ||
        bus.out_tap_Di !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_grant: got aw=%b w=%b EN=%b WE=%h A=%h Di=%h",
        bus.out_arbit_awready, bus.out_arbit_wready,
        bus.out_tap_EN, bus.out_tap_WE, bus.out_tap_A,
        bus.out_tap_Di);
    end
    tick();
    bus.in_axi_wr_req = 1'b0;
    bus.in_axi_WE     = '0;
    bus.in_axi_Di     = '0;
    bus.in_axi_rd_req = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_arbit_arready !== 1'b1 || bus.out_tap_WE !== 4'h0 ||
        bus.out_arbit_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant: got ar=%b WE=%h rv=%b want 1 0 0",
        bus.out_arbit_arready, bus.out_tap_WE,
        bus.out_arbit_rvalid);
    end
    tick();
    bus.in_axi_rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_arbit_rvalid !== 1'b1 || do_q !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_data: got rv=%b Do=%h want 1 deadbeef",
        bus.out_arbit_rvalid, do_q);
    end
    tick();
  endtask

  task automatic test_rw_together();
    bus.in_axi_rd_req = 1'b1;
    bus.in_axi_wr_req = 1'b1;
    bus.in_axi_A      = 10'd7;
    bus.in_axi_WE     = 4'hF;
    bus.in_axi_Di     = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (bus.out_arbit_awready !== 1'b1 ||
        bus.out_arbit_arready !== 1'b0) begin
      errors++;
      $display("FAIL rw_order: got aw=%b ar=%b want 1 0",
        bus.out_arbit_awready, bus.out_arbit_arready);
    end
    tick();
    bus.in_axi_wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_arbit_arready !== 1'b1 ||
        bus.out_arbit_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rw_read: got ar=%b rv=%b want 1 0",
        bus.out_arbit_arready, bus.out_arbit_rvalid);
    end
    tick();
    bus.in_axi_rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_arbit_rvalid !== 1'b1 || do_q !== 32'h0000_1234) begin
      errors++;
      $display("FAIL rw_data: got rv=%b Do=%h want 1 00001234",
        bus.out_arbit_rvalid, do_q);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_idle_priority();
    bus.in_core_req   = 1'b1;
    bus.in_core_A     = 10'd5;
    bus.in_axi_rd_req = 1'b1;
    bus.in_axi_A      = 10'd7;
    @(negedge clk);
    checks++;
    if (bus.out_arbit_arready !== 1'b1 || bus.out_core_gnt !== 1'b0 ||
        bus.out_tap_A !== 10'd7) begin
      errors++;
      $display("FAIL idle_axi_first: got ar=%b gnt=%b A=%h",
        bus.out_arbit_arready, bus.out_core_gnt, bus.out_tap_A);
    end
    tick();
    bus.in_axi_rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_core_gnt !== 1'b1 || bus.out_tap_A !== 10'd5 ||
        bus.out_arbit_rvalid !== 1'b1 || do_q !== 32'h0000_1234 ||
        bus.out_core_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_core_next: got gnt=%b A=%h arv=%b Do=%h crv=%b",
        bus.out_core_gnt, bus.out_tap_A, bus.out_arbit_rvalid,
        do_q, bus.out_core_rvalid);
    end
    tick();
    bus.in_core_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_core_rvalid !== 1'b1 || bus.out_core_gnt !== 1'b0 ||
        bus.out_arbit_rvalid !== 1'b0 || do_q !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL idle_core_rvalid: got crv=%b gnt=%b arv=%b Do=%h",
        bus.out_core_rvalid, bus.out_core_gnt,
        bus.out_arbit_rvalid, do_q);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    bit ax;
    bus.in_ap_busy    = 1'b1;
    bus.in_core_req   = 1'b1;
    bus.in_core_A     = 10'd5;
    bus.in_axi_rd_req = 1'b1;
    bus.in_axi_A      = 10'd7;
    for (int i = 0; i < 10; i++) begin
      ax = (i % 5 == 4);
      @(negedge clk);
      checks++;
      if (bus.out_arbit_arready !== ax || bus.out_core_gnt !== !ax) begin
        errors++;
        $display("FAIL starve_cyc%0d: got ar=%b gnt=%b want %b %b",
          i, bus.out_arbit_arready, bus.out_core_gnt, ax, !ax);
      end
      tick();
    end
    // A read dropped before its grant must not reach the BRAM.
    bus.in_axi_rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_arbit_arready !== 1'b0 || bus.out_tap_A !== 10'd5) begin
      errors++;
      $display("FAIL starve_drop: got ar=%b A=%h want 0 005",
        bus.out_arbit_arready, bus.out_tap_A);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    bit ax;
    bus.in_ap_busy    = 1'b1;
    bus.in_core_req   = 1'b1;
    bus.in_axi_rd_req = 1'b1;
    tick();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_core_gnt, bus.out_arbit_arready, bus.out_tap_EN,
         bus.out_core_rvalid} !== 4'b0) begin
      errors++;
      $display("FAIL mid_rst_outputs: got %b want 0000",
        {bus.out_core_gnt, bus.out_arbit_arready, bus.out_tap_EN,
         bus.out_core_rvalid});
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ax = (i == 4);
      @(negedge clk);
      checks++;
      if (bus.out_arbit_arready !== ax || bus.out_core_gnt !== !ax) begin
        errors++;
        $display("FAIL wait_cleared_cyc%0d: got ar=%b gnt=%b want %b %b",
          i, bus.out_arbit_arready, bus.out_core_gnt, ax, !ax);
      end
      tick();
    end
    idle_inputs();
    bus.in_axi_rd_req = 1'b1;
    bus.in_axi_A      = 10'd5;
    @(negedge clk);
    checks++;
    if (bus.out_arbit_arready !== 1'b1) begin
      errors++;
      $display("FAIL squash_grant: got ar=%b want 1",
        bus.out_arbit_arready);
    end
    tick();
    rst = 1'b1;
    bus.in_core_req = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_arbit_rvalid, bus.out_arbit_arready,
         bus.out_core_gnt, bus.out_tap_EN} !== 4'b0) begin
      errors++;
      $display("FAIL squash_rvalid: got %b want 0000",
        {bus.out_arbit_rvalid, bus.out_arbit_arready,
         bus.out_core_gnt, bus.out_tap_EN});
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.out_arbit_rvalid !== 1'b0 || bus.out_tap_A !== 10'd0) begin
      errors++;
      $display("FAIL squash_after: got rv=%b A=%h want 0 000",
        bus.out_arbit_rvalid, bus.out_tap_A);
    end
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_busy_write();
    bus.in_ap_busy    = 1'b1;
    bus.in_core_req   = 1'b1;
    bus.in_core_A     = 10'd5;
    bus.in_axi_wr_req = 1'b1;
    bus.in_axi_A      = 10'd9;
    bus.in_axi_WE     = 4'h3;
    bus.in_axi_Di     = 32'hAAAA_5555;
`ifdef TAP_WR_LOCK_EN
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_arbit_awready !== 1'b0 || bus.out_core_gnt !== 1'b1) begin
        errors++;
        $display("FAIL lock_cyc%0d: got aw=%b gnt=%b want 0 1",
          i, bus.out_arbit_awready, bus.out_core_gnt);
      end
      if (i > 0) begin
        checks++;
        if (bus.out_wr_blocked !== 1'b1) begin
          errors++;
          $display("FAIL lock_flag%0d: got %b want 1",
            i, bus.out_wr_blocked);
        end
      end
      tick();
    end
    bus.in_ap_busy = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_arbit_awready !== 1'b1 || bus.out_wr_blocked !== 1'b1) begin
      errors++;
      $display("FAIL lock_release: got aw=%b blk=%b want 1 1",
        bus.out_arbit_awready, bus.out_wr_blocked);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.out_wr_blocked !== 1'b1) begin
      errors++;
      $display("FAIL lock_sticky: got %b want 1", bus.out_wr_blocked);
    end
`else
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_arbit_awready !== (i == 4) ||
          bus.out_core_gnt !== (i != 4)) begin
        errors++;
        $display("FAIL busy_wr_cyc%0d: got aw=%b gnt=%b",
          i, bus.out_arbit_awready, bus.out_core_gnt);
      end
      tick();
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (bus.out_wr_blocked !== 1'b0) begin
      errors++;
      $display("FAIL busy_wr_flag: got %b want 0", bus.out_wr_blocked);
    end
`endif
    tick();
    bus.in_axi_rd_req = 1'b1;
    bus.in_axi_A      = 10'd9;
    tick();
    bus.in_axi_rd_req = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_arbit_rvalid !== 1'b1 || do_q !== 32'h0000_5555) begin
      errors++;
      $display("FAIL byte_we: got rv=%b Do=%h want 1 00005555",
        bus.out_arbit_rvalid, do_q);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_wr_rd();
    test_rw_together();
    test_idle_priority();
    test_starvation();
    test_reset_mid();
    test_busy_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end
endmodule
